// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory round-robin arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;

  // Width of a core index / rotation pointer; never narrower than 1 bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first requester at or after ptr, wrapping.
module rr_priority_picker #(
  parameter int N  = 8,
  parameter int PW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic [PW-1:0] o_win_idx,
  output logic          o_any
);

  int w_idx;

  // Scan N positions starting at ptr; the first set request wins.
  always_comb begin
    o_win     = '0;
    o_win_idx = '0;
    o_any     = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_win[w_idx] = 1'b1;
        o_win_idx    = PW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter serialising core accesses onto one single-port data RAM.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x RAM_LAT) -> ACK -> IDLE.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NCORES  = 8,
  parameter int AW      = DMEM_AW,
  parameter int DW      = DMEM_DW,
  parameter int RAM_LAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NCORES-1:0]    i_req,
  input  logic [NCORES-1:0]    i_wren,
  input  logic [NCORES*AW-1:0] i_addr,
  input  logic [NCORES*DW-1:0] i_din,
  output logic [NCORES-1:0]    o_ack,
  output logic [NCORES-1:0]    o_grant,
  output logic [DW-1:0]        o_dout,
  output logic [AW-1:0]        o_ram_addr,
  output logic [DW-1:0]        o_ram_din,
  output logic                 o_ram_wren,
  input  logic [DW-1:0]        i_ram_q
);

  localparam int PW = ptr_w(NCORES);
  localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

  arb_state_t         r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_widx;
  logic [1:0]         r_cnt;

  logic [NCORES-1:0]  w_win;
  logic [PW-1:0]      w_win_idx;
  logic               w_any;
  logic [AW-1:0]      w_sel_addr;
  logic [DW-1:0]      w_sel_din;
  logic               w_sel_wren;

  rr_priority_picker #(
    .N  (NCORES),
    .PW (PW)
  ) u_pick (
    .i_req     (i_req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  // Route the winning core's address/data/direction using the one-hot win vector.
  always_comb begin
    w_sel_addr = '0;
    w_sel_din  = '0;
    w_sel_wren = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (w_win[i]) begin
        w_sel_addr = i_addr[i*AW +: AW];
        w_sel_din  = i_din[i*DW +: DW];
        w_sel_wren = i_wren[i];
      end
    end
  end

  // Arbitration FSM; all RAM-side and core-side outputs are registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_widx     <= '0;
      r_cnt      <= '0;
      o_ack      <= '0;
      o_grant    <= '0;
      o_dout     <= '0;
      o_ram_addr <= '0;
      o_ram_din  <= '0;
      o_ram_wren <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_widx     <= w_win_idx;
            o_grant    <= w_win;
            o_ram_addr <= w_sel_addr;
            o_ram_din  <= w_sel_din;
            o_ram_wren <= w_sel_wren;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          // The registered write enable doubles as the latched direction.
          o_ram_wren <= 1'b0;
          if (o_ram_wren) begin
            o_ack   <= o_grant;
            r_state <= ACK;
          end else begin
            r_cnt   <= LAT_M1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            o_dout  <= i_ram_q;
            o_ack   <= o_grant;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ACK: begin
          o_ack   <= '0;
          o_grant <= '0;
          r_ptr   <= (r_widx == PW'(NCORES - 1)) ? '0 : r_widx + PW'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
